// File: rtl/ctrl_decode_pipe.sv
// Pipelined MIPS control decode: decodes opCode/funct into the ID/EX control word,
// sequences multi-cycle mul with busy back-pressure. Optional trap counter: ILLEGAL_TRAP_EN.
module ctrl_decode_pipe #(
  parameter int unsigned ALUOP_W    = 4,
  parameter int unsigned MUL_CYCLES = 3,
  parameter int unsigned CNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_in,
  input  logic [5:0]         opCode,
  input  logic [5:0]         funct,
  input  logic               stall,
  input  logic               flush,
  output logic               busy,
  output logic               valid_out,
  output logic               RegDst,
  output logic               Branch,
  output logic               MemReadEn,
  output logic               MemtoReg,
  output logic               MemWriteEn,
  output logic               RegWriteEn,
  output logic               ALUSrc,
  output logic               bne,
  output logic               jump,
  output logic               jal,
  output logic               jr,
  output logic [ALUOP_W-1:0] ALUOp
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic               illegal,
  output logic [CNT_W-1:0]   illegal_cnt
`endif
);

  typedef struct packed {
    logic               regdst;
    logic               branch;
    logic               memrd;
    logic               memtoreg;
    logic               memwr;
    logic               regwr;
    logic               alusrc;
    logic               bne;
    logic               jump;
    logic               jal;
    logic               jr;
    logic [ALUOP_W-1:0] aluop;
  } ctrl_t;

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  ctrl_t            ctrl_q;
  logic             valid_q;

  ctrl_t dec;
  ctrl_t mul_word;
  logic  is_mul;
  logic  legal;

  always_comb begin
    dec    = '0;
    legal  = 1'b1;
    is_mul = 1'b0;
    unique case (opCode)
      6'h00: begin
        if (funct == 6'h08) begin
          dec.jump = 1'b1;
          dec.jr   = 1'b1;
        end else begin
          dec.regdst = 1'b1;
          dec.regwr  = 1'b1;
          case (funct)
            6'h20:   dec.aluop = ALUOP_W'(0);
            6'h22:   dec.aluop = ALUOP_W'(1);
            6'h24:   dec.aluop = ALUOP_W'(2);
            6'h25:   dec.aluop = ALUOP_W'(3);
            6'h2a:   dec.aluop = ALUOP_W'(4);
            6'h26:   dec.aluop = ALUOP_W'(5);
            6'h27:   dec.aluop = ALUOP_W'(6);
            6'h00:   dec.aluop = ALUOP_W'(7);
            6'h02:   dec.aluop = ALUOP_W'(8);
            default: begin
              dec   = '0;
              legal = 1'b0;
            end
          endcase
        end
      end
      6'h08: begin dec.alusrc = 1'b1; dec.regwr = 1'b1; dec.aluop = ALUOP_W'(0); end
      6'h0c: begin dec.alusrc = 1'b1; dec.regwr = 1'b1; dec.aluop = ALUOP_W'(2); end
      6'h0d: begin dec.alusrc = 1'b1; dec.regwr = 1'b1; dec.aluop = ALUOP_W'(3); end
      6'h0e: begin dec.alusrc = 1'b1; dec.regwr = 1'b1; dec.aluop = ALUOP_W'(5); end
      6'h0a: begin dec.alusrc = 1'b1; dec.regwr = 1'b1; dec.aluop = ALUOP_W'(4); end
      6'h23: begin
        dec.alusrc   = 1'b1;
        dec.memrd    = 1'b1;
        dec.memtoreg = 1'b1;
        dec.regwr    = 1'b1;
      end
      6'h2b: begin dec.alusrc = 1'b1; dec.memwr = 1'b1; end
      6'h04: begin dec.branch = 1'b1; dec.aluop = ALUOP_W'(1); end
      6'h05: begin dec.branch = 1'b1; dec.bne = 1'b1; dec.aluop = ALUOP_W'(1); end
      6'h02: begin dec.jump = 1'b1; dec.alusrc = 1'b1; end
      6'h03: begin dec.jump = 1'b1; dec.jal = 1'b1; dec.regwr = 1'b1; end
      6'h1c: begin
        // mul never loads through dec; the issued word comes from mul_word
        if (funct == 6'h02) is_mul = 1'b1;
        else                legal  = 1'b0;
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    mul_word        = '0;
    mul_word.regdst = 1'b1;
    mul_word.regwr  = 1'b1;
    mul_word.aluop  = ALUOP_W'(9);
  end

  // Issue-cycle mul is not busy so IF/ID advances on the same edge the mul issues.
  assign busy = ((state_q == StIdle) && valid_in && is_mul && !flush) ||
                ((state_q == StMul) && (cnt_q != '0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ctrl_q  <= '0;
      valid_q <= 1'b0;
    end else if (flush) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ctrl_q  <= '0;
      valid_q <= 1'b0;
    end else if (!stall) begin
      unique case (state_q)
        StIdle: begin
          if (valid_in && is_mul) begin
            ctrl_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= CNT_W'(MUL_CYCLES - 1);
            state_q <= StMul;
          end else begin
            ctrl_q  <= valid_in ? dec : '0;
            valid_q <= valid_in & legal;
          end
        end
        StMul: begin
          if (cnt_q != '0) begin
            ctrl_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= cnt_q - CNT_W'(1);
          end else begin
            ctrl_q  <= mul_word;
            valid_q <= 1'b1;
            state_q <= StIdle;
          end
        end
      endcase
    end
  end

  assign valid_out  = valid_q;
  assign RegDst     = ctrl_q.regdst;
  assign Branch     = ctrl_q.branch;
  assign MemReadEn  = ctrl_q.memrd;
  assign MemtoReg   = ctrl_q.memtoreg;
  assign MemWriteEn = ctrl_q.memwr;
  assign RegWriteEn = ctrl_q.regwr;
  assign ALUSrc     = ctrl_q.alusrc;
  assign bne        = ctrl_q.bne;
  assign jump       = ctrl_q.jump;
  assign jal        = ctrl_q.jal;
  assign jr         = ctrl_q.jr;
  assign ALUOp      = ctrl_q.aluop;

`ifdef ILLEGAL_TRAP_EN
  logic             illegal_q;
  logic [CNT_W-1:0] illegal_cnt_q;
  logic             illegal_hit;

  assign illegal_hit = (state_q == StIdle) && valid_in && !legal;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      illegal_q     <= 1'b0;
      illegal_cnt_q <= '0;
    end else if (flush) begin
      illegal_q <= 1'b0;
    end else if (!stall) begin
      illegal_q <= illegal_hit;
      if (illegal_hit && (illegal_cnt_q != '1)) illegal_cnt_q <= illegal_cnt_q + CNT_W'(1);
    end
  end

  assign illegal     = illegal_q;
  assign illegal_cnt = illegal_cnt_q;
`endif

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Directed scoreboard bench for ctrl_decode_pipe; trap checks added when ILLEGAL_TRAP_EN is set.
module tb_ctrl_decode_pipe;

`ifdef ILLEGAL_TRAP_EN
  localparam int unsigned CNT_W = 2;
`else
  localparam int unsigned CNT_W = 8;
`endif

  typedef struct packed {
    logic       valid;
    logic       regdst;
    logic       branch;
    logic       memrd;
    logic       memtoreg;
    logic       memwr;
    logic       regwr;
    logic       alusrc;
    logic       bne;
    logic       jump;
    logic       jal;
    logic       jr;
    logic [3:0] aluop;
  } word_t;

  logic       clk;
  logic       rst;
  logic       valid_in;
  logic [5:0] opCode;
  logic [5:0] funct;
  logic       stall;
  logic       flush;
  logic       busy;
  logic       valid_out;
  logic       RegDst, Branch, MemReadEn, MemtoReg, MemWriteEn, RegWriteEn, ALUSrc;
  logic       bne, jump, jal, jr;
  logic [3:0] ALUOp;
`ifdef ILLEGAL_TRAP_EN
  logic             illegal;
  logic [CNT_W-1:0] illegal_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  word_t sb[$];

  ctrl_decode_pipe #(
    .ALUOP_W   (4),
    .MUL_CYCLES(3),
    .CNT_W     (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .opCode    (opCode),
    .funct     (funct),
    .stall     (stall),
    .flush     (flush),
    .busy      (busy),
    .valid_out (valid_out),
    .RegDst    (RegDst),
    .Branch    (Branch),
    .MemReadEn (MemReadEn),
    .MemtoReg  (MemtoReg),
    .MemWriteEn(MemWriteEn),
    .RegWriteEn(RegWriteEn),
    .ALUSrc    (ALUSrc),
    .bne       (bne),
    .jump      (jump),
    .jal       (jal),
    .jr        (jr),
    .ALUOp     (ALUOp)
`ifdef ILLEGAL_TRAP_EN
    ,
    .illegal    (illegal),
    .illegal_cnt(illegal_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic word_t sample();
    return {valid_out, RegDst, Branch, MemReadEn, MemtoReg, MemWriteEn, RegWriteEn, ALUSrc,
            bne, jump, jal, jr, ALUOp};
  endfunction

  // Reference table written straight from the instruction set; unlisted pairs give zero.
  function automatic word_t ref_word(input logic [5:0] op, input logic [5:0] fn);
    word_t w;
    w = '0;
    w.valid = 1'b1;
    case (op)
      6'h00: begin
        if (fn == 6'h08) begin
          w.jump = 1'b1; w.jr = 1'b1;
        end else begin
          w.regdst = 1'b1; w.regwr = 1'b1;
          case (fn)
            6'h20: w.aluop = 4'd0;
            6'h22: w.aluop = 4'd1;
            6'h24: w.aluop = 4'd2;
            6'h25: w.aluop = 4'd3;
            6'h2a: w.aluop = 4'd4;
            6'h26: w.aluop = 4'd5;
            6'h27: w.aluop = 4'd6;
            6'h00: w.aluop = 4'd7;
            6'h02: w.aluop = 4'd8;
            default: w = '0;
          endcase
        end
      end
      6'h08: begin w.alusrc = 1'b1; w.regwr = 1'b1; w.aluop = 4'd0; end
      6'h0c: begin w.alusrc = 1'b1; w.regwr = 1'b1; w.aluop = 4'd2; end
      6'h0d: begin w.alusrc = 1'b1; w.regwr = 1'b1; w.aluop = 4'd3; end
      6'h0e: begin w.alusrc = 1'b1; w.regwr = 1'b1; w.aluop = 4'd5; end
      6'h0a: begin w.alusrc = 1'b1; w.regwr = 1'b1; w.aluop = 4'd4; end
      6'h23: begin w.alusrc = 1'b1; w.memrd = 1'b1; w.memtoreg = 1'b1; w.regwr = 1'b1; end
      6'h2b: begin w.alusrc = 1'b1; w.memwr = 1'b1; end
      6'h04: begin w.branch = 1'b1; w.aluop = 4'd1; end
      6'h05: begin w.branch = 1'b1; w.bne = 1'b1; w.aluop = 4'd1; end
      6'h02: begin w.jump = 1'b1; w.alusrc = 1'b1; end
      6'h03: begin w.jump = 1'b1; w.jal = 1'b1; w.regwr = 1'b1; end
      default: w = '0;
    endcase
    return w;
  endfunction

  function automatic word_t mul_word();
    word_t w;
    w = '0;
    w.valid = 1'b1; w.regdst = 1'b1; w.regwr = 1'b1; w.aluop = 4'd9;
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, check combinational busy, then compare the registered word after the edge.
  task automatic step(input string tag, input logic v, input logic [5:0] op,
                      input logic [5:0] fn, input logic st, input logic fl,
                      input logic exp_busy, input word_t exp);
    word_t e;
    valid_in = v; opCode = op; funct = fn; stall = st; flush = fl;
    #1;
    chk({tag, "_busy"}, {31'd0, busy}, {31'd0, exp_busy});
    sb.push_back(exp);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk(tag, {16'd0, sample()}, {16'd0, e});
  endtask

  logic [5:0] sw_op[23] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                            6'h00, 6'h08, 6'h0c, 6'h0d, 6'h0e, 6'h0a, 6'h23, 6'h2b, 6'h04,
                            6'h05, 6'h02, 6'h03, 6'h3f, 6'h00};
  logic [5:0] sw_fn[23] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h26, 6'h27, 6'h00, 6'h02,
                            6'h08, 6'h11, 6'h00, 6'h3f, 6'h01, 6'h02, 6'h04, 6'h20, 6'h00,
                            6'h00, 6'h00, 6'h00, 6'h00, 6'h3f};

  initial begin
    word_t z;
    word_t add_w;
    word_t sub_w;
    z     = '0;
    add_w = ref_word(6'h00, 6'h20);
    sub_w = ref_word(6'h00, 6'h22);

    rst = 1'b0; valid_in = 1'b0; opCode = '0; funct = '0; stall = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_word", {16'd0, sample()}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;

    step("add_after_reset", 1'b1, 6'h00, 6'h20, 1'b0, 1'b0, 1'b0, add_w);

    for (int i = 0; i < 23; i++) begin
      step("sweep", 1'b1, sw_op[i], sw_fn[i], 1'b0, 1'b0, 1'b0, ref_word(sw_op[i], sw_fn[i]));
      if (sw_op[i] == 6'h05) chk("bne_fields", {27'd0, bne, ALUOp}, {27'd0, 1'b1, 4'd1});
      if (sw_op[i] == 6'h00 && sw_fn[i] == 6'h08)
        chk("jr_fields", {30'd0, jr, jump}, 32'd3);
    end

    // mul held on IF/ID while busy, then the next instruction follows immediately
    step("mul_b0", 1'b1, 6'h1c, 6'h02, 1'b0, 1'b0, 1'b1, z);
    step("mul_b1", 1'b1, 6'h1c, 6'h02, 1'b0, 1'b0, 1'b1, z);
    step("mul_b2", 1'b1, 6'h1c, 6'h02, 1'b0, 1'b0, 1'b1, z);
    step("mul_issue", 1'b1, 6'h1c, 6'h02, 1'b0, 1'b0, 1'b0, mul_word());
    step("after_mul", 1'b1, 6'h00, 6'h20, 1'b0, 1'b0, 1'b0, add_w);

    step("stall_hold", 1'b1, 6'h00, 6'h22, 1'b1, 1'b0, 1'b0, add_w);
    step("stall_release", 1'b1, 6'h00, 6'h22, 1'b0, 1'b0, 1'b0, sub_w);

    // stall for two cycles at counter=1 stretches the mul by two cycles
    step("smul_b0", 1'b1, 6'h1c, 6'h02, 1'b0, 1'b0, 1'b1, z);
    step("smul_b1", 1'b1, 6'h1c, 6'h02, 1'b0, 1'b0, 1'b1, z);
    step("smul_st0", 1'b1, 6'h1c, 6'h02, 1'b1, 1'b0, 1'b1, z);
    step("smul_st1", 1'b1, 6'h1c, 6'h02, 1'b1, 1'b0, 1'b1, z);
    step("smul_b2", 1'b1, 6'h1c, 6'h02, 1'b0, 1'b0, 1'b1, z);
    step("smul_issue", 1'b1, 6'h1c, 6'h02, 1'b0, 1'b0, 1'b0, mul_word());

    step("pre_flush", 1'b1, 6'h00, 6'h20, 1'b0, 1'b0, 1'b0, add_w);
    step("flush_clear", 1'b1, 6'h00, 6'h22, 1'b0, 1'b1, 1'b0, z);
    step("flush_idle_mul", 1'b1, 6'h1c, 6'h02, 1'b0, 1'b1, 1'b0, z);
    step("flush_idle_chk", 1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0, z);

    step("fmul_b0", 1'b1, 6'h1c, 6'h02, 1'b0, 1'b0, 1'b1, z);
    step("fmul_flush_stall", 1'b1, 6'h1c, 6'h02, 1'b1, 1'b1, 1'b1, z);
    step("fmul_idle", 1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0, z);
    step("fmul_next", 1'b1, 6'h00, 6'h20, 1'b0, 1'b0, 1'b0, add_w);

    // asynchronous reset in the middle of a mul
    step("rmul_b0", 1'b1, 6'h1c, 6'h02, 1'b0, 1'b0, 1'b1, z);
    valid_in = 1'b0;
    #1;
    chk("rmul_busy_pre", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rmul_busy_rst", {31'd0, busy}, 32'd0);
    chk("rmul_word_rst", {16'd0, sample()}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step("rmul_add", 1'b1, 6'h00, 6'h20, 1'b0, 1'b0, 1'b0, add_w);

`ifdef ILLEGAL_TRAP_EN
    chk("ill_cnt_reset", {30'd0, illegal_cnt}, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      step("ill_word", 1'b1, 6'h3f, 6'h00, 1'b0, 1'b0, 1'b0, z);
      chk("ill_pulse", {31'd0, illegal}, 32'd1);
      chk("ill_cnt", {30'd0, illegal_cnt}, (k > 3) ? 32'd3 : k);
    end
    step("ill_legal", 1'b1, 6'h00, 6'h20, 1'b0, 1'b0, 1'b0, add_w);
    chk("ill_clear", {31'd0, illegal}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
